// File: rtl/usb_ls_pkg.sv
// Shared definitions for the low-speed USB receive path.
package usb_ls_pkg;

    localparam int unsigned CYC_PER_BIT_DEF = 33;
    localparam int unsigned SAMPLE_PT_DEF   = 16;
    localparam int unsigned RST_CYCLES_DEF  = 125000;

    // Line state encodings, {DP, DM} as seen with low-speed polarity
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_SYNC  = 3'd1,
        RX_DATA  = 3'd2,
        RX_EOP   = 3'd3,
        RX_ABORT = 3'd4
    } rx_state_e;

endpackage

// File: rtl/usb_ls_rx_if.sv
// Pin, enable and decoded-packet signals of one low-speed receiver.
interface usb_ls_rx_if;

    logic       iDP;
    logic       iDM;
    logic       iEN;
    logic [1:0] oLINE;
    logic       oACTIVE;
    logic       oSOP;
    logic [7:0] oDATA;
    logic       oVALID;
    logic       oEOP;
    logic       oERR;
    logic       oBUSRST;

    modport master (
        output iDP, iDM, iEN,
        input  oLINE, oACTIVE, oSOP, oDATA, oVALID, oEOP, oERR, oBUSRST
    );

    modport slave (
        input  iDP, iDM, iEN,
        output oLINE, oACTIVE, oSOP, oDATA, oVALID, oEOP, oERR, oBUSRST
    );

endinterface

// File: rtl/usb_line_sync.sv
// Two-flop pin synchronizer with line-state decode and a change flag.
module usb_line_sync
    import usb_ls_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iDP,
    input  logic       iDM,
    output logic [1:0] line,
    output logic       line_chg
);

    logic [1:0] meta;

    // Synchronize {DP,DM}; line_chg is high in the first cycle of a new line state
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            meta     <= LINE_J;
            line     <= LINE_J;
            line_chg <= 1'b0;
        end else begin
            meta     <= {iDP, iDM};
            line     <= meta;
            line_chg <= (meta != line);
        end
    end

endmodule

// File: rtl/usb_ls_rx.sv
// Low-speed USB packet receiver: bit recovery, NRZI, unstuffing, SYNC/EOP, bytes.
module usb_ls_rx
    import usb_ls_pkg::*;
#(
    parameter int unsigned CYC_PER_BIT = CYC_PER_BIT_DEF,
    parameter int unsigned SAMPLE_PT   = SAMPLE_PT_DEF,
    parameter int unsigned RST_CYCLES  = RST_CYCLES_DEF
) (
    input  logic        iCLK,
    input  logic        iRSTN,
    usb_ls_rx_if.slave  bus
);

    localparam int unsigned TW       = $clog2(CYC_PER_BIT);
    localparam int unsigned IDLE_CYC = 2 * CYC_PER_BIT;
    localparam int unsigned IW       = $clog2(IDLE_CYC + 1);
    localparam int unsigned RW       = $clog2(RST_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'(RX_IDLE);
    localparam logic [2:0] S_SYNC  = 3'(RX_SYNC);
    localparam logic [2:0] S_DATA  = 3'(RX_DATA);
    localparam logic [2:0] S_EOP   = 3'(RX_EOP);
    localparam logic [2:0] S_ABORT = 3'(RX_ABORT);

    logic [1:0]    line;
    logic          line_chg;
    logic [TW-1:0] tmr;
    logic [IW-1:0] idle_cnt;
    logic [RW-1:0] se0_cnt;
    logic          busrst_q;

    logic [2:0] state,    state_n;
    logic [2:0] zeros,    zeros_n;
    logic [2:0] ones,     ones_n;
    logic [2:0] bitcnt,   bitcnt_n;
    logic [7:0] shreg,    shreg_n;
    logic [7:0] data_q,   data_n;
    logic [1:0] prev_lvl, prev_n;
    logic       err_pend, err_pend_n;
    logic       active_q, active_n;
    logic       sop_q,    sop_n;
    logic       valid_q,  valid_n;
    logic       eop_q,    eop_n;
    logic       err_q,    err_n;

    logic strobe_c;
    logic is_jk_c;
    logic nrzi_c;
    logic idle_ok_c;

    usb_line_sync u_sync (
        .iCLK     (iCLK),
        .iRSTN    (iRSTN),
        .iDP      (bus.iDP),
        .iDM      (bus.iDM),
        .line     (line),
        .line_chg (line_chg)
    );

    assign strobe_c  = (tmr == TW'(SAMPLE_PT));
    assign is_jk_c   = (line == LINE_J) || (line == LINE_K);
    assign nrzi_c    = (line == prev_lvl);
    assign idle_ok_c = (line == LINE_J) && (idle_cnt == IW'(IDLE_CYC));

    // Bit timer: realigns to every line transition, otherwise free-runs one bit period
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN)
            tmr <= '0;
        else if (line_chg || (tmr == TW'(CYC_PER_BIT - 1)))
            tmr <= '0;
        else
            tmr <= tmr + TW'(1);
    end

    // Cycles since the last line change, saturating at two bit periods
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN)
            idle_cnt <= '0;
        else if (line_chg)
            idle_cnt <= '0;
        else if (idle_cnt != IW'(IDLE_CYC))
            idle_cnt <= idle_cnt + IW'(1);
    end

    // SE0 duration counter for bus-reset detection
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            se0_cnt  <= '0;
            busrst_q <= 1'b0;
        end else begin
            if (line != LINE_SE0)
                se0_cnt <= '0;
            else if (se0_cnt != RW'(RST_CYCLES))
                se0_cnt <= se0_cnt + RW'(1);
            busrst_q <= (line == LINE_SE0) && (se0_cnt == RW'(RST_CYCLES));
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state    <= S_IDLE;
            zeros    <= '0;
            ones     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            data_q   <= '0;
            prev_lvl <= LINE_J;
            err_pend <= 1'b0;
            active_q <= 1'b0;
            sop_q    <= 1'b0;
            valid_q  <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            zeros    <= zeros_n;
            ones     <= ones_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            data_q   <= data_n;
            prev_lvl <= prev_n;
            err_pend <= err_pend_n;
            active_q <= active_n;
            sop_q    <= sop_n;
            valid_q  <= valid_n;
            eop_q    <= eop_n;
            err_q    <= err_n;
        end
    end

    // Next-state and output decode, acting only on sample strobes
    always_comb begin
        state_n    = state;
        zeros_n    = zeros;
        ones_n     = ones;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        data_n     = data_q;
        prev_n     = prev_lvl;
        err_pend_n = err_pend;
        sop_n      = 1'b0;
        valid_n    = 1'b0;
        eop_n      = 1'b0;
        err_n      = 1'b0;

        if (strobe_c && is_jk_c)
            prev_n = line;

        case (state)
            S_IDLE: begin
                // The first K after idle J is itself the first SYNC zero
                if (strobe_c && (line == LINE_K)) begin
                    state_n = S_SYNC;
                    zeros_n = 3'd1;
                end
            end
            S_SYNC: begin
                if (strobe_c) begin
                    if (line == LINE_SE1) begin
                        state_n = S_ABORT;
                        eop_n   = 1'b1;
                        err_n   = 1'b1;
                    end else if (line == LINE_SE0) begin
                        state_n = S_IDLE;
                    end else if (!nrzi_c) begin
                        if (zeros != 3'd7)
                            zeros_n = zeros + 3'd1;
                    end else if (zeros >= 3'd5) begin
                        // Stuffing run starts with the first data bit
                        state_n  = S_DATA;
                        sop_n    = 1'b1;
                        ones_n   = 3'd0;
                        bitcnt_n = 3'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (strobe_c) begin
                    if (line == LINE_SE0) begin
                        state_n    = S_EOP;
                        err_pend_n = (bitcnt != 3'd0);
                    end else if (line == LINE_SE1) begin
                        state_n = S_ABORT;
                        eop_n   = 1'b1;
                        err_n   = 1'b1;
                    end else if (ones == 3'd6) begin
                        if (nrzi_c) begin
                            state_n = S_ABORT;
                            eop_n   = 1'b1;
                            err_n   = 1'b1;
                        end else begin
                            ones_n = 3'd0;
                        end
                    end else begin
                        shreg_n  = {nrzi_c, shreg[7:1]};
                        ones_n   = nrzi_c ? (ones + 3'd1) : 3'd0;
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            data_n  = shreg_n;
                            valid_n = 1'b1;
                        end
                    end
                end
            end
            S_EOP: begin
                if (strobe_c) begin
                    if (line == LINE_J) begin
                        state_n = S_IDLE;
                        eop_n   = 1'b1;
                        err_n   = err_pend;
                    end else if (line != LINE_SE0) begin
                        state_n = S_ABORT;
                        eop_n   = 1'b1;
                        err_n   = 1'b1;
                    end
                end
            end
            S_ABORT: begin
                if (idle_ok_c)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Disable overrides everything; a packet in flight is closed as bad
        if (!bus.iEN) begin
            state_n    = S_IDLE;
            zeros_n    = 3'd0;
            ones_n     = 3'd0;
            bitcnt_n   = 3'd0;
            err_pend_n = 1'b0;
            data_n     = data_q;
            sop_n      = 1'b0;
            valid_n    = 1'b0;
            eop_n      = (state == S_DATA) || (state == S_EOP);
            err_n      = eop_n;
        end

        // Active through the end-of-packet pulse, dropping the cycle after
        active_n = (state_n == S_DATA) || (state_n == S_EOP) || (eop_n && active_q);
    end

    assign bus.oLINE   = line;
    assign bus.oACTIVE = active_q;
    assign bus.oSOP    = sop_q;
    assign bus.oDATA   = data_q;
    assign bus.oVALID  = valid_q;
    assign bus.oEOP    = eop_q;
    assign bus.oERR    = err_q;
    assign bus.oBUSRST = busrst_q;

endmodule

// File: tb/tb_usb_ls_rx.sv
// Scoreboard bench for usb_ls_rx: packets are encoded from byte lists and
// expected SOP/byte/EOP events are queued ahead of the monitor.
`timescale 1ns/1ps
module tb_usb_ls_rx;
    import usb_ls_pkg::*;

    localparam int unsigned RST_CYC = 2000;

    typedef struct {
        int         kind;   // 0 SOP, 1 byte, 2 EOP
        logic [7:0] data;
        logic       err;
    } ev_t;

    logic iCLK  = 1'b0;
    logic iRSTN = 1'b0;

    usb_ls_rx_if bus ();

    usb_ls_rx #(
        .CYC_PER_BIT (33),
        .SAMPLE_PT   (16),
        .RST_CYCLES  (RST_CYC)
    ) dut (
        .iCLK  (iCLK),
        .iRSTN (iRSTN),
        .bus   (bus)
    );

    always #10 iCLK = ~iCLK;

    ev_t        exp_q[$];
    logic [7:0] pkt[$];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_ev(input int k, input logic [7:0] d, input logic e);
        ev_t ev;
        ev.kind = k;
        ev.data = d;
        ev.err  = e;
        exp_q.push_back(ev);
    endtask

    task automatic got_ev(input int k, input logic [7:0] d, input logic e);
        ev_t ev;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h err=%0b, required none", k, d, e);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != k || (k == 1 && ev.data != d) || (k == 2 && ev.err != e)) begin
                bad++;
                $display("FAIL event: got kind=%0d data=%02h err=%0b, required kind=%0d data=%02h err=%0b",
                         k, d, e, ev.kind, ev.data, ev.err);
            end
        end
    endtask

    // Reference: SOP, every whole byte, then EOP flagged bad if bits are left over
    task automatic expect_pkt(input int nextra);
        push_ev(0, 8'h00, 1'b0);
        foreach (pkt[i]) push_ev(1, pkt[i], 1'b0);
        push_ev(2, 8'h00, (nextra % 8) != 0);
    endtask

    // Monitor: compare every DUT event against the head of the queue
    always @(negedge iCLK) begin
        if (iRSTN) begin
            if (bus.oSOP) begin
                got_ev(0, 8'h00, 1'b0);
                check("active_at_sop", 32'(bus.oACTIVE), 32'd1);
            end
            if (bus.oVALID)
                got_ev(1, bus.oDATA, 1'b0);
            if (bus.oEOP) begin
                got_ev(2, 8'h00, bus.oERR);
                check("active_at_eop", 32'(bus.oACTIVE), 32'd1);
            end
        end
    end

    task automatic drive(input logic [1:0] l, input int n);
        {bus.iDP, bus.iDM} = l;
        repeat (n) @(negedge iCLK);
    endtask

    // Encode SYNC + pkt + residual bits, stuff, NRZI, then SE0/J; optional cut
    // at a stream bit: kind 1 drops iEN, kind 2 pulses reset and stops
    task automatic send(input int per, input int nextra, input logic [7:0] xval,
                        input bit stuff, input int cut, input int cut_kind);
        bit         raw[$];
        bit         st[$];
        int         ones;
        logic [1:0] lvl;
        for (int i = 0; i < 7; i++) st.push_back(1'b0);
        st.push_back(1'b1);
        foreach (pkt[b]) for (int i = 0; i < 8; i++) raw.push_back(pkt[b][i]);
        for (int i = 0; i < nextra; i++) raw.push_back(xval[i]);
        ones = 0;
        foreach (raw[i]) begin
            st.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = LINE_J;
        foreach (st[i]) begin
            if (i == cut && cut_kind == 1)
                bus.iEN = 1'b0;
            if (i == cut && cut_kind == 2) begin
                iRSTN = 1'b0;
                {bus.iDP, bus.iDM} = LINE_J;
                repeat (3) @(negedge iCLK);
                check("rst_mid_line", 32'(bus.oLINE), 32'h1);
                check("rst_mid_outs", 32'({bus.oACTIVE, bus.oSOP, bus.oVALID, bus.oEOP,
                                          bus.oERR, bus.oBUSRST, bus.oDATA}), 32'h0);
                repeat (4 * per) @(negedge iCLK);
                iRSTN = 1'b1;
                drive(LINE_J, 8 * per);
                return;
            end
            if (!st[i])
                lvl = (lvl == LINE_J) ? LINE_K : LINE_J;
            drive(lvl, per);
        end
        drive(LINE_SE0, 2 * per);
        drive(LINE_J, 8 * per);
        bus.iEN = 1'b1;
    endtask

    initial begin
        int per;
        int nx;
        int len;
        bus.iDP = 1'b0;
        bus.iDM = 1'b1;
        bus.iEN = 1'b1;
        repeat (5) @(negedge iCLK);
        check("reset_line", 32'(bus.oLINE), 32'h1);
        check("reset_outs", 32'({bus.oACTIVE, bus.oSOP, bus.oVALID, bus.oEOP,
                                bus.oERR, bus.oBUSRST, bus.oDATA}), 32'h0);
        iRSTN = 1'b1;
        drive(LINE_J, 10 * 33);

        // Single PID
        pkt = '{8'hD2};
        expect_pkt(0);
        send(33, 0, 8'h00, 1'b1, -1, 0);
        check("drained_pid", exp_q.size(), 0);

        // Stuffed 0xFF followed by 0x01
        pkt = '{8'hFF, 8'h01};
        expect_pkt(0);
        send(33, 0, 8'h00, 1'b1, -1, 0);
        check("drained_stuff", exp_q.size(), 0);

        // Seven unstuffed ones: error, no bytes
        pkt.delete();
        push_ev(0, 8'h00, 1'b0);
        push_ev(2, 8'h00, 1'b1);
        send(33, 7, 8'h7F, 1'b0, -1, 0);
        check("drained_stufferr", exp_q.size(), 0);
        check("active_after_stufferr", 32'(bus.oACTIVE), 32'd0);

        // Same packet at both bit-period extremes
        pkt = '{8'hA5, 8'h3C, 8'h7E};
        expect_pkt(0);
        send(32, 0, 8'h00, 1'b1, -1, 0);
        check("drained_p32", exp_q.size(), 0);
        expect_pkt(0);
        send(34, 0, 8'h00, 1'b1, -1, 0);
        check("drained_p34", exp_q.size(), 0);

        // 12 data bits then SE0
        pkt = '{8'hC3};
        expect_pkt(4);
        send(33, 4, 8'h0A, 1'b1, -1, 0);
        check("drained_residual", exp_q.size(), 0);

        // Bus reset detection and clear
        drive(LINE_SE0, RST_CYC / 2);
        check("busrst_early", 32'(bus.oBUSRST), 32'd0);
        drive(LINE_SE0, RST_CYC / 2 + 50);
        check("busrst_set", 32'(bus.oBUSRST), 32'd1);
        drive(LINE_J, 10);
        check("busrst_clear", 32'(bus.oBUSRST), 32'd0);
        drive(LINE_J, 8 * 33);

        // iEN dropped in the middle of the second byte
        pkt = '{8'hD2, 8'h5A};
        push_ev(0, 8'h00, 1'b0);
        push_ev(1, 8'hD2, 1'b0);
        push_ev(2, 8'h00, 1'b1);
        send(33, 0, 8'h00, 1'b1, 19, 1);
        check("drained_en_drop", exp_q.size(), 0);
        check("active_after_en_drop", 32'(bus.oACTIVE), 32'd0);

        // Receiver back in IDLE after re-enable
        pkt = '{8'h69, 8'h81};
        expect_pkt(0);
        send(33, 0, 8'h00, 1'b1, -1, 0);
        check("drained_after_en", exp_q.size(), 0);

        // Reset in the middle of the first byte: SOP only, no EOP
        pkt = '{8'hD2};
        push_ev(0, 8'h00, 1'b0);
        send(33, 0, 8'h00, 1'b1, 13, 2);
        check("drained_rst", exp_q.size(), 0);

        // Randomized packets
        for (int n = 0; n < 14; n++) begin
            per = 32 + int'($urandom_range(0, 2));
            len = 1 + int'($urandom_range(0, 2));
            nx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            pkt.delete();
            for (int i = 0; i < len; i++)
                pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            expect_pkt(nx);
            send(per, nx, 8'($urandom), 1'b1, -1, 0);
            check("drained_rand", exp_q.size(), 0);
        end

        check("queue_end", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_ls_rx.md
# usb_ls_rx

Low-speed (1.5 Mb/s) USB packet receiver for the USB proxy. Takes one raw D+/D- pair from a GPIO port and delivers decoded packet bytes to the proxy's forwarding and inspection logic. Internally it synchronizes the pins, decodes line state, recovers bit timing from the 50 MHz clock, NRZI-decodes, removes stuffed bits, detects SYNC/EOP and assembles bytes LSB-first. One instance sits on the host side and one on the device side.

## Interface
Parameters:
- CYC_PER_BIT, 33: nominal clock cycles per bit (50 MHz / 1.5 MHz, truncated).
- SAMPLE_PT, 16: counter value at which a bit is sampled (mid-bit).
- RST_CYCLES, 125000: SE0 duration in cycles (2.5 ms) that flags bus reset.

Ports:
- iCLK, in, 1: system clock, 50 MHz.
- iRSTN, in, 1: reset, asynchronous, active-low.
- iDP, in, 1: raw D+ pin.
- iDM, in, 1: raw D- pin.
- iEN, in, 1: receive enable; low while the proxy drives this pair.
- oLINE, out, 2: synchronized line state: 00 SE0, 01 J, 10 K, 11 SE1.
- oACTIVE, out, 1: high from SYNC accepted until EOP completes or abort.
- oSOP, out, 1: one-cycle pulse when SYNC is accepted.
- oDATA, out, 8: last assembled byte; held until the next byte.
- oVALID, out, 1: one-cycle pulse, oDATA is new.
- oEOP, out, 1: one-cycle pulse at packet end (normal or aborted).
- oERR, out, 1: qualifies oEOP; high only in the oEOP cycle if the packet was bad.
- oBUSRST, out, 1: level; SE0 held for at least RST_CYCLES.

## Operation
- Low-speed polarity: J = (DP=0, DM=1), K = (DP=1, DM=0).
- Two-flop synchronizer on iDP/iDM. Reset value is J (DP=0, DM=1), so oLINE resets to 01.
- Bit timer: counter 0..CYC_PER_BIT-1, wraps. Reloads to 0 on every change of the synchronized line state. A sample strobe fires at count == SAMPLE_PT.
- NRZI: at each strobe, J/K equal to the previous sampled J/K gives bit 1, a change gives bit 0. The previous-level register resets to J.
- States:
  - IDLE: wait for a sampled K, then go to SYNC.
  - SYNC: count decoded 0s. A 1 after at least 5 zeros → DATA, pulse oSOP. A 1 after fewer zeros, or a sampled SE0 → IDLE, no outputs.
  - DATA: shift bits LSB-first into the byte register; every 8th kept bit updates oDATA and pulses oVALID.
  - EOP: entered on a sampled SE0. The next sampled J pulses oEOP and returns to IDLE.
  - ABORT: wait for an idle line, then go to IDLE.
- Bit unstuffing: ones counter (0..6). After six 1s the next bit is discarded if it is 0. If it is 1, that is a stuff error: pulse oEOP with oERR=1 immediately, enter ABORT, no further oVALID.
- EOP error rule: oERR=1 with oEOP if the residual bit count is not 0 mod 8 when SE0 is sampled. Residual bits are dropped.
- ABORT exit: a J lasting at least 2 bit periods (2·CYC_PER_BIT cycles without a line change).
- iEN low: synchronous return to IDLE, counters cleared, oVALID/oSOP/oEOP suppressed. If deasserted while oACTIVE=1, pulse oEOP with oERR=1 that cycle.
- oBUSRST: a separate SE0 duration counter, saturating. It clears on any non-SE0 line state.
- SE1 sampled anywhere in SYNC or DATA is treated as a stuff error.

## Timing
- Pin-to-oLINE latency: 2 cycles.
- oVALID occurs 1 cycle after the strobe that samples the 8th kept bit of a byte.
- oEOP occurs 1 cycle after the strobe sampling the first J following SE0.
- oACTIVE rises in the same cycle as oSOP and falls in the cycle after oEOP.
- Simultaneous events: the same-cycle oVALID and oEOP combination is impossible by construction. If iEN falls on a byte-completion strobe, iEN wins and oVALID is suppressed.
- Tolerated bit period: 32–34 cycles. Resync occurs at least every 7 bits because of stuffing.
- Reset values: all outputs 0 except oLINE=01. Assertion of iRSTN mid-packet clears everything immediately; no oEOP is emitted.

## Structure
- Shared package usb_ls_pkg holds:
  - the line-state encodings;
  - the receiver state enum (IDLE, SYNC, DATA, EOP, ABORT);
  - the default CYC_PER_BIT, SAMPLE_PT and RST_CYCLES constants.
- One sub-module, usb_line_sync: the two-flop synchronizer plus line-state decode and a change flag. It is reused later by the transmit side for collision checks.

## Test plan
- KJKJKJKK SYNC, then PID 0xD2, then 2-bit SE0 and J, at 33 cycles/bit → oSOP, one oVALID with oDATA=0xD2, oEOP with oERR=0.
- Bytes 0xFF,0x01 with a correctly stuffed 0 after six 1s → oDATA 0xFF then 0x01, oERR=0.
- Seven consecutive 1s after SYNC → oEOP with oERR=1, no oVALID after the error, and oACTIVE drops.
- Same packet driven at 32 and at 34 cycles/bit → identical byte stream, oERR=0.
- SE0 after 12 data bits → one oVALID, then oEOP with oERR=1. SE0 held for 125000 cycles → oBUSRST=1, which clears on J.
- iEN dropped mid-byte → oEOP with oERR=1 and state IDLE. iRSTN asserted mid-packet → all outputs 0 and oLINE=01 with no oEOP.
